// File: rtl/roll_removal_engine.sv
// Roll removal engine: loads a DEPTH x WIDTH occupancy grid one row per handshake, then runs
// one removal pass per cycle until a pass removes nothing. A pass removes every roll that has
// fewer than THRESH occupied 8-neighbours, with all counts taken from the grid as it stood at
// the start of that pass.
// Optional feature: define ROLL_PART1_COUNT_EN to add the part1_count output, which holds the
// number of rolls removed by the first pass.
module roll_removal_engine #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned THRESH = 4,
    parameter int unsigned CNT_W  = $clog2(WIDTH * DEPTH + 1),
    parameter int unsigned PASS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [WIDTH-1:0]  row_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  total_removed,
    output logic [PASS_W-1:0] pass_count
`ifdef ROLL_PART1_COUNT_EN
    ,
    output logic [CNT_W-1:0]  part1_count
`endif
);

    typedef enum logic [1:0] {StIdle, StLoad, StPass, StDone} state_e;

    localparam int unsigned       RIDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RIDX_W-1:0] LastRow = RIDX_W'(DEPTH - 1);
    localparam logic [3:0]        ThreshV = 4'(THRESH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   grid_q [DEPTH];
    logic [WIDTH-1:0]   grid_d [DEPTH];
    logic [RIDX_W-1:0]  row_idx_q, row_idx_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [PASS_W-1:0]  pass_q, pass_d;

    // Grid with a one-cell empty border so out-of-grid neighbours need no bounds checks.
    logic [WIDTH+1:0]   pad [DEPTH+2];
    logic [WIDTH-1:0]   mask [DEPTH];
    logic [CNT_W-1:0]   pop;

`ifdef ROLL_PART1_COUNT_EN
    logic               first_q, first_d;
    logic [CNT_W-1:0]   part1_q, part1_d;
`endif

    // Build the bordered copy of the current grid.
    always_comb begin
        pad[0]       = '0;
        pad[DEPTH+1] = '0;
        for (int r = 0; r < DEPTH; r++) begin
            pad[r+1] = {1'b0, grid_q[r], 1'b0};
        end
    end

    // Accessible mask and its popcount, all from the pass-start grid (Jacobi update).
    always_comb begin : mask_calc
        logic [3:0] cnt;
        pop = '0;
        cnt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            mask[r] = '0;
        end
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                cnt = '0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        if (!(dr == 1 && dc == 1)) begin
                            cnt = cnt + {3'b000, pad[r+dr][c+dc]};
                        end
                    end
                end
                mask[r][c] = grid_q[r][c] & (cnt < ThreshV);
                pop = pop + CNT_W'(mask[r][c]);
            end
        end
    end

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        row_idx_d = row_idx_q;
        total_d   = total_q;
        pass_d    = pass_q;
`ifdef ROLL_PART1_COUNT_EN
        first_d   = first_q;
        part1_d   = part1_q;
`else
        // No first-pass bookkeeping in this build.
`endif
        row_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    state_d   = StLoad;
                    row_idx_d = '0;
                    total_d   = '0;
                    pass_d    = '0;
                    for (int r = 0; r < DEPTH; r++) begin
                        grid_d[r] = '0;
                    end
`ifdef ROLL_PART1_COUNT_EN
                    first_d = 1'b0;
                    part1_d = '0;
`endif
                end
            end
            StLoad: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (row_valid) begin
                    grid_d[row_idx_q] = row_data;
                    if (row_idx_q == LastRow) begin
                        state_d   = StPass;
                        row_idx_d = '0;
`ifdef ROLL_PART1_COUNT_EN
                        first_d = 1'b1;
`endif
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
            end
            StPass: begin
                busy = 1'b1;
                for (int r = 0; r < DEPTH; r++) begin
                    grid_d[r] = grid_q[r] & ~mask[r];
                end
                total_d = total_q + pop;
`ifdef ROLL_PART1_COUNT_EN
                if (first_q) begin
                    part1_d = pop;
                    first_d = 1'b0;
                end
`endif
                if (pop != '0) begin
                    if (pass_q != '1) begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Grid, row index and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                grid_q[r] <= '0;
            end
            row_idx_q <= '0;
            total_q   <= '0;
            pass_q    <= '0;
`ifdef ROLL_PART1_COUNT_EN
            first_q   <= 1'b0;
            part1_q   <= '0;
`endif
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                grid_q[r] <= grid_d[r];
            end
            row_idx_q <= row_idx_d;
            total_q   <= total_d;
            pass_q    <= pass_d;
`ifdef ROLL_PART1_COUNT_EN
            first_q   <= first_d;
            part1_q   <= part1_d;
`endif
        end
    end

    assign total_removed = total_q;
    assign pass_count    = pass_q;
`ifdef ROLL_PART1_COUNT_EN
    assign part1_count   = part1_q;
`endif

endmodule

// File: tb/tb_roll_removal_engine.sv
// Directed testbench for roll_removal_engine: reference grid, empty grid, single roll,
// THRESH=1 pair, load stalls, ignored start pulses and reset mid-run.
module tb_roll_removal_engine;

    logic        clk = 1'b0;
    logic        rst, start, row_valid;
    logic [9:0]  row_data;
    logic        row_ready, busy, done;
    logic [6:0]  total_removed;
    logic [15:0] pass_count;
`ifdef ROLL_PART1_COUNT_EN
    logic [6:0]  part1_count;
    logic [1:0]  t_part1;
`endif

    logic        t_start, t_valid;
    logic [1:0]  t_data;
    logic        t_ready, t_busy, t_done;
    logic [1:0]  t_total;
    logic [15:0] t_pass;

    int n_checks = 0;
    int n_bad    = 0;
    int lat;
    logic [9:0] stim [10];

    string ref_rows [10] = '{"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.",
                             "@@.@@@@.@@", ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@",
                             ".@@@@@@@@.", "@.@.@@@.@."};

    always #5 clk = ~clk;

    roll_removal_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_data     (row_data),
        .busy         (busy),
        .done         (done),
        .total_removed(total_removed),
        .pass_count   (pass_count)
`ifdef ROLL_PART1_COUNT_EN
        ,
        .part1_count  (part1_count)
`endif
    );

    roll_removal_engine #(.WIDTH(2), .DEPTH(1), .THRESH(1)) dut_t1 (
        .clk          (clk),
        .rst          (rst),
        .start        (t_start),
        .row_valid    (t_valid),
        .row_ready    (t_ready),
        .row_data     (t_data),
        .busy         (t_busy),
        .done         (t_done),
        .total_removed(t_total),
        .pass_count   (t_pass)
`ifdef ROLL_PART1_COUNT_EN
        ,
        .part1_count  (t_part1)
`endif
    );

    function automatic logic [9:0] str2row(input string s);
        logic [9:0] v = '0;
        for (int c = 0; c < 10; c++) v[c] = (s[c] == 8'h40);
        return v;
    endfunction

    task automatic set_ref();
        for (int r = 0; r < 10; r++) stim[r] = str2row(ref_rows[r]);
    endtask

    // poke==1: pulse start while row 5 is being accepted.
    task automatic load_rows(input bit gaps, input int poke);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 0; r < 10; r++) begin
            if (gaps) begin
                row_valid = 1'b0;
                row_data  = 10'h3ff;
                @(posedge clk); #1;
            end
            row_valid = 1'b1;
            row_data  = stim[r];
            start     = (poke == 1 && r == 5);
            @(posedge clk); #1;
            start = 1'b0;
        end
        row_valid = 1'b0;
        row_data  = '0;
    endtask

    // Counts cycles from last row acceptance to done; poke==2 pulses start in the 2nd pass.
    task automatic wait_done(input int poke);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            start = (poke == 2 && lat == 1);
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic check_ref_result(input string tag);
        n_checks++;
        if (total_removed !== 7'd43) begin
            n_bad++; $display("FAIL %s_total: got %0d want 43", tag, total_removed);
        end
        n_checks++;
        if (pass_count !== 16'd9) begin
            n_bad++; $display("FAIL %s_passes: got %0d want 9", tag, pass_count);
        end
        n_checks++;
        if (lat != 10) begin
            n_bad++; $display("FAIL %s_latency: got %0d want 10", tag, lat);
        end
        n_checks++;
        if (busy !== 1'b0 || row_ready !== 1'b0) begin
            n_bad++; $display("FAIL %s_idle_flags: got busy=%b ready=%b want 0 0", tag, busy,
                              row_ready);
        end
`ifdef ROLL_PART1_COUNT_EN
        n_checks++;
        if (part1_count !== 7'd13) begin
            n_bad++; $display("FAIL %s_part1: got %0d want 13", tag, part1_count);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({row_ready, busy, done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {row_ready, busy, done});
        end
        n_checks++;
        if (total_removed !== 7'd0 || pass_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", total_removed,
                              pass_count);
        end
    endtask

    task automatic test_reference();
        set_ref();
        load_rows(1'b0, 0);
        wait_done(0);
        check_ref_result("ref");
    endtask

    task automatic test_empty();
        for (int r = 0; r < 10; r++) stim[r] = '0;
        // Start from DONE: counters cleared in the same cycle.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (total_removed !== 7'd0 || pass_count !== 16'd0 || done !== 1'b0) begin
            n_bad++; $display("FAIL restart_clear: got %0d/%0d done=%b want 0/0 0",
                              total_removed, pass_count, done);
        end
        n_checks++;
        if (busy !== 1'b1 || row_ready !== 1'b1) begin
            n_bad++; $display("FAIL restart_load: got busy=%b ready=%b want 1 1", busy,
                              row_ready);
        end
        for (int r = 0; r < 10; r++) begin
            row_valid = 1'b1;
            row_data  = stim[r];
            @(posedge clk); #1;
        end
        row_valid = 1'b0;
        wait_done(0);
        n_checks++;
        if (total_removed !== 7'd0 || pass_count !== 16'd0 || lat != 1) begin
            n_bad++; $display("FAIL empty: got %0d/%0d lat=%0d want 0/0 lat=1", total_removed,
                              pass_count, lat);
        end
    endtask

    task automatic test_single();
        for (int r = 0; r < 10; r++) stim[r] = '0;
        stim[0] = 10'b00_0000_0001;
        load_rows(1'b0, 0);
        wait_done(0);
        n_checks++;
        if (total_removed !== 7'd1 || pass_count !== 16'd1 || lat != 2) begin
            n_bad++; $display("FAIL single: got %0d/%0d lat=%0d want 1/1 lat=2", total_removed,
                              pass_count, lat);
        end
`ifdef ROLL_PART1_COUNT_EN
        n_checks++;
        if (part1_count !== 7'd1) begin
            n_bad++; $display("FAIL single_part1: got %0d want 1", part1_count);
        end
`endif
    endtask

    task automatic test_thresh1();
        int cyc;
        t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        t_valid = 1'b1;
        t_data  = 2'b11;
        @(posedge clk); #1;
        t_valid = 1'b0;
        cyc = 0;
        while (t_done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (t_total !== 2'd0 || t_pass !== 16'd0 || cyc != 1) begin
            n_bad++; $display("FAIL thresh1_pair: got %0d/%0d lat=%0d want 0/0 lat=1", t_total,
                              t_pass, cyc);
        end
    endtask

    task automatic test_gaps();
        set_ref();
        load_rows(1'b1, 0);
        wait_done(0);
        check_ref_result("gaps");
    endtask

    task automatic test_start_ignored();
        set_ref();
        load_rows(1'b0, 1);
        wait_done(2);
        check_ref_result("start_busy");
    endtask

    task automatic test_rst_mid_pass();
        set_ref();
        load_rows(1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (total_removed !== 7'd25 || pass_count !== 16'd2) begin
            n_bad++; $display("FAIL two_passes: got %0d/%0d want 25/2", total_removed,
                              pass_count);
        end
        n_checks++;
        if (busy !== 1'b1 || row_ready !== 1'b0) begin
            n_bad++; $display("FAIL pass_flags: got busy=%b ready=%b want 1 0", busy, row_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({row_ready, busy, done} !== 3'b000 || total_removed !== 7'd0 ||
            pass_count !== 16'd0) begin
            n_bad++; $display("FAIL rst_mid_pass: got flags=%b %0d/%0d want 000 0/0",
                              {row_ready, busy, done}, total_removed, pass_count);
        end
        load_rows(1'b0, 0);
        wait_done(0);
        check_ref_result("after_rst");
    endtask

    task automatic test_rst_start_same();
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || row_ready !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL rst_wins: got busy=%b ready=%b done=%b want 0 0 0", busy,
                              row_ready, done);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        t_start   = 1'b0;
        t_valid   = 1'b0;
        t_data    = '0;
        test_reset();
        test_reference();
        test_empty();
        test_single();
        test_thresh1();
        test_gaps();
        test_start_ignored();
        test_rst_mid_pass();
        test_rst_start_same();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
